// File: rtl/rename_multi.sv
// Two-wide register rename stage.
// Keeps a speculative RAT (updated at rename), a committed RAT (updated at
// retire) and a circular free list of physical registers. Allocation pops
// from head, retirement pushes the superseded mapping at tail, and
// commit_head tracks where head would be if only retired renames had
// happened, so a flush can rewind head and the SRAT in one cycle.
module rename_multi #(
  parameter int NUM_PHYS_REGS = 64,
  parameter int NUM_ARCH_REGS = 32,
  localparam int PW = $clog2(NUM_PHYS_REGS),
  localparam int FL_DEPTH = NUM_PHYS_REGS - NUM_ARCH_REGS
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [1:0]    in_valid,
  output logic          in_ready,
  input  logic [4:0]    rs1_0,
  input  logic [4:0]    rs2_0,
  input  logic [4:0]    rd_0,
  input  logic [4:0]    rs1_1,
  input  logic [4:0]    rs2_1,
  input  logic [4:0]    rd_1,
  input  logic          rd_we_0,
  input  logic          rd_we_1,
  output logic [PW-1:0] phys_rs1_0,
  output logic [PW-1:0] phys_rs2_0,
  output logic [PW-1:0] phys_rs1_1,
  output logic [PW-1:0] phys_rs2_1,
  output logic [PW-1:0] phys_rd_0,
  output logic [PW-1:0] phys_rd_1,
  output logic [PW-1:0] old_phys_rd_0,
  output logic [PW-1:0] old_phys_rd_1,
  input  logic [1:0]    retire_valid,
  input  logic          retire_we_0,
  input  logic          retire_we_1,
  input  logic [4:0]    retire_rd_0,
  input  logic [4:0]    retire_rd_1,
  input  logic [PW-1:0] retire_phys_rd_0,
  input  logic [PW-1:0] retire_phys_rd_1,
  input  logic [PW-1:0] retire_old_phys_rd_0,
  input  logic [PW-1:0] retire_old_phys_rd_1,
  input  logic          flush,
  output logic [PW:0]   free_count,
  output logic          fl_error
);

  // Free-list index width; pointers are PW bits wide and wrap naturally
  // because FL_DEPTH is a power of two.
  localparam int FW = (FL_DEPTH > 1) ? $clog2(FL_DEPTH) : 1;

  logic [PW-1:0] srat [NUM_ARCH_REGS];
  logic [PW-1:0] crat [NUM_ARCH_REGS];
  logic [PW-1:0] crat_upd [NUM_ARCH_REGS];
  logic [PW-1:0] fl [FL_DEPTH];

  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [PW-1:0] commit_head;
  logic [PW:0]   count;

  // ---------------- rename side ----------------
  logic          alloc_0;
  logic          alloc_1;
  logic [1:0]    need;
  logic          fire;
  logic [PW-1:0] head_1;
  logic [1:0]    pops;

  assign alloc_0  = in_valid[0] & rd_we_0 & (rd_0 != 5'd0);
  assign alloc_1  = in_valid[1] & rd_we_1 & (rd_1 != 5'd0);
  assign need     = {1'b0, alloc_0} + {1'b0, alloc_1};
  // Only the registered count is used: a register freed by a retire this
  // cycle becomes allocatable next cycle.
  assign in_ready = !flush && (count >= (PW+1)'(need));
  assign fire     = (|in_valid) & in_ready;
  assign pops     = fire ? need : 2'd0;
  assign head_1   = head + PW'(alloc_0);

  assign phys_rd_0 = alloc_0 ? fl[head[FW-1:0]]   : '0;
  assign phys_rd_1 = alloc_1 ? fl[head_1[FW-1:0]] : '0;

  // Lane 1 sees lane 0's new destination when it names the same register.
  assign phys_rs1_0 = srat[rs1_0];
  assign phys_rs2_0 = srat[rs2_0];
  assign phys_rs1_1 = (alloc_0 && rs1_1 == rd_0) ? phys_rd_0 : srat[rs1_1];
  assign phys_rs2_1 = (alloc_0 && rs2_1 == rd_0) ? phys_rd_0 : srat[rs2_1];

  assign old_phys_rd_0 = alloc_0 ? srat[rd_0] : '0;
  assign old_phys_rd_1 = !alloc_1 ? '0 :
                         (alloc_0 && rd_1 == rd_0) ? phys_rd_0 : srat[rd_1];

  // ---------------- retire side ----------------
  logic          ret_0;
  logic          ret_1;
  logic [1:0]    pushes;
  logic [PW-1:0] tail_1;
  logic [PW-1:0] tail_next;
  logic [PW-1:0] commit_head_next;
  logic [PW:0]   count_sum;
  logic [PW:0]   count_next;
  logic [PW-1:0] flush_diff;
  logic [PW:0]   flush_count;
  logic          overflow;
  logic          underflow;

  assign ret_0            = retire_valid[0] & retire_we_0 & (retire_rd_0 != 5'd0);
  assign ret_1            = retire_valid[1] & retire_we_1 & (retire_rd_1 != 5'd0);
  assign pushes           = {1'b0, ret_0} + {1'b0, ret_1};
  assign tail_1           = tail + PW'(ret_0);
  assign tail_next        = tail + PW'(pushes);
  assign commit_head_next = commit_head + PW'(pushes);
  assign count_sum        = count + (PW+1)'(pushes);
  assign count_next       = count_sum - (PW+1)'(pops);
  assign overflow         = (pushes != 2'd0) && (count_sum > (PW+1)'(FL_DEPTH));
  assign underflow        = (PW+1)'(pops) > count;

  // After a flush every uncommitted register is free again; a zero
  // pointer distance therefore means a full list, not an empty one.
  assign flush_diff  = tail_next - commit_head_next;
  assign flush_count = (flush_diff[FW-1:0] == '0) ? (PW+1)'(FL_DEPTH)
                                                  : (PW+1)'(flush_diff[FW-1:0]);

  // Committed mapping including this cycle's retires (lane 1 wins).
  generate
    for (genvar gi = 0; gi < NUM_ARCH_REGS; gi++) begin : g_crat_upd
      assign crat_upd[gi] = (ret_1 && retire_rd_1 == 5'(gi)) ? retire_phys_rd_1 :
                            (ret_0 && retire_rd_0 == 5'(gi)) ? retire_phys_rd_0 :
                            crat[gi];
    end
  endgenerate

  assign free_count = count;

  // Committed RAT tracks retired destinations.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_ARCH_REGS; i++) crat[i] <= PW'(i);
    end else begin
      for (int i = 0; i < NUM_ARCH_REGS; i++) crat[i] <= crat_upd[i];
    end
  end

  // Speculative RAT: restored from the committed view on flush, else
  // updated by accepted allocations (lane 1 written last so it wins).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_ARCH_REGS; i++) srat[i] <= PW'(i);
    end else if (flush) begin
      for (int i = 0; i < NUM_ARCH_REGS; i++) srat[i] <= crat_upd[i];
    end else if (fire) begin
      if (alloc_0) srat[rd_0] <= phys_rd_0;
      if (alloc_1) srat[rd_1] <= phys_rd_1;
    end
  end

  // Free-list storage: retired old mappings are appended at tail.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int j = 0; j < FL_DEPTH; j++) fl[j] <= PW'(NUM_ARCH_REGS + j);
    end else begin
      if (ret_0) fl[tail[FW-1:0]]   <= retire_old_phys_rd_0;
      if (ret_1) fl[tail_1[FW-1:0]] <= retire_old_phys_rd_1;
    end
  end

  // Pointers, occupancy and the sticky error flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head        <= '0;
      tail        <= '0;
      commit_head <= '0;
      count       <= (PW+1)'(FL_DEPTH);
      fl_error    <= 1'b0;
    end else begin
      tail        <= tail_next;
      commit_head <= commit_head_next;
      fl_error    <= fl_error | overflow | underflow;
      if (flush) begin
        head  <= commit_head_next;
        count <= flush_count;
      end else begin
        head  <= head + PW'(pops);
        count <= count_next;
      end
    end
  end

endmodule

// File: tb/tb_rename_multi.sv
// Directed bench for rename_multi: expected values are queued when a step
// is driven and popped in order as the DUT outputs are sampled.
module tb_rename_multi;
  localparam int PW = 6;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [1:0]    in_valid;
  logic          in_ready;
  logic [4:0]    rs1_0, rs2_0, rd_0, rs1_1, rs2_1, rd_1;
  logic          rd_we_0, rd_we_1;
  logic [PW-1:0] phys_rs1_0, phys_rs2_0, phys_rs1_1, phys_rs2_1;
  logic [PW-1:0] phys_rd_0, phys_rd_1, old_phys_rd_0, old_phys_rd_1;
  logic [1:0]    retire_valid;
  logic          retire_we_0, retire_we_1;
  logic [4:0]    retire_rd_0, retire_rd_1;
  logic [PW-1:0] retire_phys_rd_0, retire_phys_rd_1;
  logic [PW-1:0] retire_old_phys_rd_0, retire_old_phys_rd_1;
  logic          flush;
  logic [PW:0]   free_count;
  logic          fl_error;

  rename_multi dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .rs1_0(rs1_0), .rs2_0(rs2_0), .rd_0(rd_0),
    .rs1_1(rs1_1), .rs2_1(rs2_1), .rd_1(rd_1),
    .rd_we_0(rd_we_0), .rd_we_1(rd_we_1),
    .phys_rs1_0(phys_rs1_0), .phys_rs2_0(phys_rs2_0),
    .phys_rs1_1(phys_rs1_1), .phys_rs2_1(phys_rs2_1),
    .phys_rd_0(phys_rd_0), .phys_rd_1(phys_rd_1),
    .old_phys_rd_0(old_phys_rd_0), .old_phys_rd_1(old_phys_rd_1),
    .retire_valid(retire_valid), .retire_we_0(retire_we_0), .retire_we_1(retire_we_1),
    .retire_rd_0(retire_rd_0), .retire_rd_1(retire_rd_1),
    .retire_phys_rd_0(retire_phys_rd_0), .retire_phys_rd_1(retire_phys_rd_1),
    .retire_old_phys_rd_0(retire_old_phys_rd_0), .retire_old_phys_rd_1(retire_old_phys_rd_1),
    .flush(flush), .free_count(free_count), .fl_error(fl_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  task automatic expect_val(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.exp = v;
    sb.push_back(e);
  endtask

  task automatic check_val(input logic [31:0] obs);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty: got %0d required a queued expectation", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.exp) else begin
        errors++;
        $error("FAIL %s: got %0d required %0d", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic clear_inputs();
    in_valid = 2'b00;
    rs1_0 = 5'd0; rs2_0 = 5'd0; rd_0 = 5'd0; rd_we_0 = 1'b0;
    rs1_1 = 5'd0; rs2_1 = 5'd0; rd_1 = 5'd0; rd_we_1 = 1'b0;
    retire_valid = 2'b00; retire_we_0 = 1'b0; retire_we_1 = 1'b0;
    retire_rd_0 = 5'd0; retire_rd_1 = 5'd0;
    retire_phys_rd_0 = '0; retire_phys_rd_1 = '0;
    retire_old_phys_rd_0 = '0; retire_old_phys_rd_1 = '0;
    flush = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    #1;
  endtask

  initial begin
    // ---- reset state ----
    do_reset();
    $display("step: reset state");
    rs1_0 = 5'd7; rs2_0 = 5'd9; rs1_1 = 5'd13; rs2_1 = 5'd31;
    expect_val("rst_free_count", 32);
    expect_val("rst_in_ready", 1);
    expect_val("rst_fl_error", 0);
    expect_val("rst_rs1_0", 7);
    expect_val("rst_rs2_0", 9);
    expect_val("rst_rs1_1", 13);
    expect_val("rst_rs2_1", 31);
    expect_val("rst_phys_rd_0", 0);
    #1;
    check_val(free_count); check_val(in_ready); check_val(fl_error);
    check_val(phys_rs1_0); check_val(phys_rs2_0); check_val(phys_rs1_1);
    check_val(phys_rs2_1); check_val(phys_rd_0);

    // ---- same-rd group with intra-group bypass ----
    $display("step: paired rename rd=5 both lanes");
    clear_inputs();
    in_valid = 2'b11; rd_0 = 5'd5; rd_we_0 = 1'b1;
    rs1_1 = 5'd5; rd_1 = 5'd5; rd_we_1 = 1'b1;
    expect_val("pair_phys_rd_0", 32);
    expect_val("pair_phys_rs1_1", 32);
    expect_val("pair_phys_rd_1", 33);
    expect_val("pair_old_rd_1", 32);
    expect_val("pair_old_rd_0", 5);
    #1;
    check_val(phys_rd_0); check_val(phys_rs1_1); check_val(phys_rd_1);
    check_val(old_phys_rd_1); check_val(old_phys_rd_0);
    tick();
    clear_inputs();
    rs1_0 = 5'd5;
    expect_val("pair_srat5", 33);
    expect_val("pair_free_count", 30);
    expect_val("pair_idle_phys_rd_0", 0);
    #1;
    check_val(phys_rs1_0); check_val(free_count); check_val(phys_rd_0);

    // ---- rename three, retire first, flush in the same cycle ----
    do_reset();
    $display("step: rename 3, retire+flush");
    in_valid = 2'b11; rd_0 = 5'd1; rd_we_0 = 1'b1; rd_1 = 5'd2; rd_we_1 = 1'b1;
    expect_val("fl3_rd_0", 32);
    expect_val("fl3_rd_1", 33);
    #1;
    check_val(phys_rd_0); check_val(phys_rd_1);
    tick();
    clear_inputs();
    in_valid = 2'b01; rd_0 = 5'd3; rd_we_0 = 1'b1;
    expect_val("fl3_rd_third", 34);
    #1;
    check_val(phys_rd_0);
    tick();
    clear_inputs();
    retire_valid = 2'b01; retire_we_0 = 1'b1; retire_rd_0 = 5'd1;
    retire_phys_rd_0 = 6'd32; retire_old_phys_rd_0 = 6'd1;
    flush = 1'b1; in_valid = 2'b01; rd_0 = 5'd6; rd_we_0 = 1'b1;
    expect_val("fl3_ready_during_flush", 0);
    #1;
    check_val(in_ready);
    tick();
    clear_inputs();
    rs1_0 = 5'd1; rs2_0 = 5'd2; rs1_1 = 5'd3;
    in_valid = 2'b01; rd_0 = 5'd4; rd_we_0 = 1'b1;
    expect_val("fl3_crat1", 32);
    expect_val("fl3_srat2_restored", 2);
    expect_val("fl3_srat3_restored", 3);
    expect_val("fl3_free_count", 32);
    expect_val("fl3_next_alloc", 33);
    expect_val("fl3_old_rd_0", 4);
    #1;
    check_val(phys_rs1_0); check_val(phys_rs2_0); check_val(phys_rs1_1);
    check_val(free_count); check_val(phys_rd_0); check_val(old_phys_rd_0);
    tick();
    clear_inputs();
    expect_val("fl3_free_after", 31);
    #1;
    check_val(free_count);

    // ---- drain the free list ----
    do_reset();
    $display("step: allocate all 32");
    for (int i = 0; i < 16; i++) begin
      in_valid = 2'b11; rd_0 = 5'd1; rd_we_0 = 1'b1; rd_1 = 5'd2; rd_we_1 = 1'b1;
      expect_val("drain_rd_0", 32'(32 + 2 * i));
      expect_val("drain_rd_1", 32'(33 + 2 * i));
      expect_val("drain_old_rd_0", (i == 0) ? 32'd1 : 32'(30 + 2 * i));
      #1;
      check_val(phys_rd_0); check_val(phys_rd_1); check_val(old_phys_rd_0);
      tick();
    end
    clear_inputs();
    in_valid = 2'b01; rd_0 = 5'd3; rd_we_0 = 1'b1;
    expect_val("empty_free_count", 0);
    expect_val("empty_ready_alloc", 0);
    #1;
    check_val(free_count); check_val(in_ready);
    rd_we_0 = 1'b0;
    expect_val("empty_ready_no_we", 1);
    #1;
    check_val(in_ready);
    rd_we_0 = 1'b1; rd_0 = 5'd0;
    expect_val("empty_ready_rd0", 1);
    expect_val("empty_phys_rd_rd0", 0);
    #1;
    check_val(in_ready); check_val(phys_rd_0);
    tick();
    expect_val("empty_count_after_rd0", 0);
    #1;
    check_val(free_count);

    // ---- retire frees a register while rename waits ----
    $display("step: retire into empty list with pending alloc");
    clear_inputs();
    in_valid = 2'b01; rd_0 = 5'd3; rd_we_0 = 1'b1;
    retire_valid = 2'b01; retire_we_0 = 1'b1; retire_rd_0 = 5'd1;
    retire_phys_rd_0 = 6'd32; retire_old_phys_rd_0 = 6'd5;
    expect_val("ret_ready_same_cycle", 0);
    #1;
    check_val(in_ready);
    tick();
    retire_valid = 2'b00; retire_we_0 = 1'b0;
    expect_val("ret_free_count", 1);
    expect_val("ret_ready_next", 1);
    expect_val("ret_phys_rd_0", 5);
    expect_val("ret_old_rd_0", 3);
    #1;
    check_val(free_count); check_val(in_ready); check_val(phys_rd_0); check_val(old_phys_rd_0);
    tick();
    clear_inputs();
    rs1_0 = 5'd3;
    expect_val("ret_srat3", 5);
    expect_val("ret_free_after", 0);
    expect_val("ret_no_error", 0);
    #1;
    check_val(phys_rs1_0); check_val(free_count); check_val(fl_error);

    // ---- overflow sets sticky error; async reset clears it ----
    do_reset();
    $display("step: push into full free list");
    retire_valid = 2'b01; retire_we_0 = 1'b1; retire_rd_0 = 5'd4;
    retire_phys_rd_0 = 6'd40; retire_old_phys_rd_0 = 6'd4;
    tick();
    clear_inputs();
    expect_val("ovf_error_set", 1);
    #1;
    check_val(fl_error);
    repeat (3) tick();
    expect_val("ovf_error_held", 1);
    #1;
    check_val(fl_error);
    #2 reset_n = 1'b0;
    #1;
    expect_val("ovf_error_async_clr", 0);
    expect_val("ovf_count_async_rst", 32);
    check_val(fl_error); check_val(free_count);
    tick();
    reset_n = 1'b1;
    #1;

    checks++;
    assert (sb.size() == 0) else begin
      errors++;
      $error("FAIL scoreboard_leftover: got %0d entries required 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
